// File: rtl/exa_crosb_demux.sv
// exa_crosb_demux -- packet-granular 1-to-N demultiplexer (crossbar ingress).
//
// The destination is read from the head beat of each packet. Every beat up to
// and including LAST is then steered to that lane through a single registered
// output stage that keeps full throughput under backpressure. A head beat whose
// destination is out of range has its whole packet discarded, and ERR_o pulses
// once for it.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   DATA_i/VALID_i/LAST_i/DEST_i, READY_o   input beat stream (DEST_i is used on the head beat only)
//   DATA_o/VALID_o/LAST_o, READY_i          per-lane output streams (at most one lane valid)
//   ERR_o               one-cycle pulse after an out-of-range head beat is accepted
//
// Optional build macro EXA_DEMUX_STATS_EN adds:
//   PKT_CNT_o[k]        wrapping count of LAST beats drained on lane k
//   DROP_CNT_o          wrapping count of ERR_o pulses
module exa_crosb_demux #(
  parameter int data_width = 128,
  parameter int output_num = 16,
  parameter int sel_width  = (output_num > 1) ? $clog2(output_num) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [data_width-1:0] DATA_i,
  input  logic                  VALID_i,
  input  logic                  LAST_i,
  input  logic [sel_width-1:0]  DEST_i,
  output logic                  READY_o,
  output logic [data_width-1:0] DATA_o [output_num-1:0],
  output logic [output_num-1:0] VALID_o,
  output logic [output_num-1:0] LAST_o,
  input  logic [output_num-1:0] READY_i,
  output logic                  ERR_o
`ifdef EXA_DEMUX_STATS_EN
  ,
  output logic [output_num-1:0][15:0] PKT_CNT_o,
  output logic [15:0]                 DROP_CNT_o
`endif
);

  typedef enum logic [1:0] {HEAD, BODY, DROP} state_t;

  // One extra bit so that a limit equal to 2**sel_width can be represented.
  localparam logic [sel_width:0] LANE_LIMIT = (sel_width+1)'(output_num);

  state_t                state_q, state_d;
  logic                  out_vld, out_last;
  logic [data_width-1:0] out_data;
  logic [sel_width-1:0]  out_sel, dest_q;
  logic                  err_q;

  logic accept, head_bad, load, lane_ready;

  assign lane_ready = READY_i[out_sel];
  assign accept     = VALID_i && READY_o;
  assign head_bad   = ({1'b0, DEST_i} >= LANE_LIMIT);
  assign load       = accept && ((state_q == BODY) || ((state_q == HEAD) && !head_bad));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= HEAD;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (accept) begin
      case (state_q)
        HEAD:       if (!LAST_i) state_d = head_bad ? DROP : BODY;
        BODY, DROP: if (LAST_i)  state_d = HEAD;
        default:    state_d = HEAD;
      endcase
    end
  end

  // Output register; a load takes priority over a drain so a new beat can
  // replace the one leaving in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      out_data <= '0;
      out_sel  <= '0;
      dest_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= accept && (state_q == HEAD) && head_bad;
      if (load) begin
        out_vld  <= 1'b1;
        out_last <= LAST_i;
        out_data <= DATA_i;
        out_sel  <= (state_q == HEAD) ? DEST_i : dest_q;
        if (state_q == HEAD) dest_q <= DEST_i;
      end else if (out_vld && lane_ready) begin
        out_vld <= 1'b0;
      end
    end
  end

  // Outputs
  always_comb begin
    READY_o = !reset && ((state_q == DROP) || !out_vld || lane_ready);
    ERR_o   = err_q;
    VALID_o = '0;
    LAST_o  = '0;
    for (int unsigned k = 0; k < output_num; k++) begin
      DATA_o[k]  = out_data;
      VALID_o[k] = out_vld && (out_sel == sel_width'(k));
      LAST_o[k]  = out_last && (out_sel == sel_width'(k));
    end
  end

`ifdef EXA_DEMUX_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      PKT_CNT_o  <= '0;
      DROP_CNT_o <= '0;
    end else begin
      for (int unsigned k = 0; k < output_num; k++) begin
        if (VALID_o[k] && LAST_o[k] && READY_i[k]) PKT_CNT_o[k] <= PKT_CNT_o[k] + 16'd1;
      end
      if (err_q) DROP_CNT_o <= DROP_CNT_o + 16'd1;
    end
  end
`endif

endmodule
